// File: rtl/corner_adjust.sv
// Button-driven editor for four quadrilateral corners: selection, single-step and
// auto-repeat moves with per-axis saturation, plus a delayed change strobe.
module corner_adjust #(
  parameter int STEP         = 1,
  parameter int REPEAT_DELAY = 16_250_000,
  parameter int REPEAT_RATE  = 3_250_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       hold,
  output logic [1:0] sel,
  output logic [9:0] x1,
  output logic [9:0] x2,
  output logic [9:0] x3,
  output logic [9:0] x4,
  output logic [8:0] y1,
  output logic [8:0] y2,
  output logic [8:0] y3,
  output logic [8:0] y4,
  output logic       update
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [10:0]   X_MAX     = 11'd639;
  localparam logic [9:0]    Y_MAX     = 10'd479;

  // S_IDLE with a held direction means no first step happened yet (e.g. after hold).
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       dir, dir_q;
  logic             selh_q;
  logic [1:0]       sel_q, sel_d;
  logic [3:0][9:0]  x_q, x_d;
  logic [3:0][8:0]  y_q, y_d;
  logic             chg_q, chg_d;
  logic             update_q;
  logic             step;
  logic [9:0]       xc, x_new;
  logic [8:0]       yc, y_new;
  logic [10:0]      xw;
  logic [9:0]       yw;

  assign dir = {btn_up, btn_down, btn_left, btn_right};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (hold || dir == 4'b0000) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (dir != dir_q) begin
      step    = 1'b1;
      state_d = S_DELAY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            step    = 1'b1;
            state_d = S_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (cnt_q == RATE_LAST) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Saturating move of the currently selected corner; opposite buttons cancel.
  always_comb begin
    xc    = x_q[sel_q];
    yc    = y_q[sel_q];
    x_new = xc;
    y_new = yc;
    xw    = '0;
    yw    = '0;
    if (btn_right && !btn_left) begin
      xw    = {1'b0, xc} + 11'(STEP);
      x_new = (xw > X_MAX) ? X_MAX[9:0] : xw[9:0];
    end else if (btn_left && !btn_right) begin
      xw    = {1'b0, xc} - 11'(STEP);
      x_new = xw[10] ? 10'd0 : xw[9:0];
    end
    if (btn_down && !btn_up) begin
      yw    = {1'b0, yc} + 10'(STEP);
      y_new = (yw > Y_MAX) ? Y_MAX[8:0] : yw[8:0];
    end else if (btn_up && !btn_down) begin
      yw    = {1'b0, yc} - 10'(STEP);
      y_new = yw[9] ? 9'd0 : yw[8:0];
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (step) begin
      x_d[sel_q] = x_new;
      y_d[sel_q] = y_new;
    end
    sel_d = sel_q;
    if (!hold && btn_sel && !selh_q) sel_d = sel_q + 2'd1;
    chg_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dir_q    <= '0;
      selh_q   <= 1'b0;
      sel_q    <= 2'd0;
      x_q      <= {10'd639, 10'd639, 10'd0, 10'd0};
      y_q      <= {9'd0, 9'd479, 9'd479, 9'd0};
      chg_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir;
      selh_q   <= btn_sel;
      sel_q    <= sel_d;
      x_q      <= x_d;
      y_q      <= y_d;
      chg_q    <= chg_d;
      update_q <= chg_q;
    end
  end

  assign sel    = sel_q;
  assign x1     = x_q[0];
  assign x2     = x_q[1];
  assign x3     = x_q[2];
  assign x4     = x_q[3];
  assign y1     = y_q[0];
  assign y2     = y_q[1];
  assign y3     = y_q[2];
  assign y4     = y_q[3];
  assign update = update_q;

endmodule
